// File: rtl/ptr_update_unit.sv
// Sequential pointer writer: read source pointer, compute candidate, bounds-check, write back or fault.
// Optional label-size table and range checks are compiled in with `define PTR_BOUNDS_CHECK_EN.
module ptr_update_unit #(
    parameter int LBID_W = 12,
    parameter int OFS_W  = 16,
    parameter int PA_W   = 6,
    parameter int LT_AW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [PA_W-1:0]   op_p0,
    input  logic [PA_W-1:0]   op_pw,
    input  logic [OFS_W-1:0]  op_imm,
    input  logic [LBID_W-1:0] op_lbid,
    output logic [PA_W-1:0]   p0,
    input  logic [LBID_W-1:0] lbid0,
    input  logic [OFS_W-1:0]  ofs0,
    output logic [PA_W-1:0]   pw,
    output logic [LBID_W-1:0] lbidw,
    output logic [OFS_W-1:0]  ofsw,
    output logic              we,
    input  logic              lt_we,
    input  logic [LT_AW-1:0]  lt_addr,
    input  logic [OFS_W-1:0]  lt_limit,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE,
        S_FAULT
    } state_t;

    localparam logic [1:0] OP_PLIMM   = 2'b00;
    localparam logic [1:0] OP_PADD    = 2'b01;
    localparam logic [1:0] OP_PCP     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b11;

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_code;
    logic [PA_W-1:0]     r_p0;
    logic [PA_W-1:0]     r_pw;
    logic [OFS_W-1:0]    r_imm;
    logic [LBID_W-1:0]   r_lbid;
    logic [LBID_W-1:0]   r_rd_lbid;
    logic [OFS_W-1:0]    r_rd_ofs;
    logic [LBID_W-1:0]   r_cand_lbid;
    logic [OFS_W-1:0]    r_cand_ofs;
    logic [1:0]          r_fault_code;

    logic [LBID_W-1:0]   w_cand_lbid;
    logic [OFS_W:0]      w_sum;
    logic [OFS_W-1:0]    w_cand_ofs;
    logic [1:0]          w_fault_code;
    logic                w_fault;

    // Candidate pointer; the sum carries one extra bit so a negative PADD result is visible.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_cand_lbid = r_rd_lbid;
        w_sum       = {1'b0, r_rd_ofs};
        case (r_code)
            OP_PLIMM: begin
                w_cand_lbid = r_lbid;
                w_sum       = '0;
            end
            OP_PADD:  w_sum = {1'b0, r_rd_ofs} + {r_imm[OFS_W-1], r_imm};
            default:  ;
        endcase
    end

    assign w_cand_ofs = w_sum[OFS_W-1:0];

`ifdef PTR_BOUNDS_CHECK_EN
    localparam logic [1:0] FC_UNDER = 2'b01;
    localparam logic [1:0] FC_RANGE = 2'b10;

    logic [OFS_W-1:0] r_lt [2**LT_AW];
    logic [OFS_W-1:0] w_limit;

    // NOTE: the table is deliberately cleared by reset so unprogrammed labels always fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**LT_AW; i++) begin
                r_lt[i] <= '0;
            end
        end else if (lt_we) begin
            r_lt[lt_addr] <= lt_limit;
        end
    end

    // Lookup reads the pre-edge contents, so a same-cycle table write is not seen by this check.
    assign w_limit = r_lt[w_cand_lbid[LT_AW-1:0]];

    always_comb begin
        w_fault_code = FC_NONE;
        if (r_code == OP_ILLEGAL) begin
            w_fault_code = FC_ILLEGAL;
        end else if (w_sum[OFS_W]) begin
            w_fault_code = FC_UNDER;
        end else if (w_cand_ofs >= w_limit) begin
            w_fault_code = FC_RANGE;
        end
    end
`else
    logic w_unused_lt;

    // Without the table the PADD sum simply wraps; the carry bit and table port are dropped.
    assign w_unused_lt  = ^{lt_we, lt_addr, lt_limit, w_sum[OFS_W]};
    assign w_fault_code = (r_code == OP_ILLEGAL) ? FC_ILLEGAL : FC_NONE;
`endif

    assign w_fault = (w_fault_code != FC_NONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (op_valid) w_next = S_READ;
            S_READ:  w_next = S_CALC;
            S_CALC:  w_next = w_fault ? S_FAULT : S_WRITE;
            S_WRITE: w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_code       <= OP_PLIMM;
            r_p0         <= '0;
            r_pw         <= '0;
            r_imm        <= '0;
            r_lbid       <= '0;
            r_rd_lbid    <= '0;
            r_rd_ofs     <= '0;
            r_cand_lbid  <= '0;
            r_cand_ofs   <= '0;
            r_fault_code <= FC_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_code <= op_code;
                        r_p0   <= op_p0;
                        r_pw   <= op_pw;
                        r_imm  <= op_imm;
                        r_lbid <= op_lbid;
                    end
                end
                S_READ: begin
                    r_rd_lbid <= lbid0;
                    r_rd_ofs  <= ofs0;
                end
                S_CALC: begin
                    r_cand_lbid <= w_cand_lbid;
                    r_cand_ofs  <= w_cand_ofs;
                    if (w_fault) begin
                        r_fault_code <= w_fault_code;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_ready = 1'b0;
        we       = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        case (r_state)
            S_IDLE:  op_ready = 1'b1;
            S_WRITE: begin
                we   = 1'b1;
                done = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign p0         = r_p0;
    assign pw         = r_pw;
    assign lbidw      = r_cand_lbid;
    assign ofsw       = r_cand_ofs;
    assign fault_code = r_fault_code;

endmodule

// File: doc/ptr_update_unit.md
# ptr_update_unit

Sequential writer for the pointer register file. It accepts one pointer operation at a time (load label, add offset, copy), reads the source pointer through a register-file read port, and checks the resulting offset against a per-label size table. It then writes the result back through the file's write port, or reports a fault. It sits between instruction decode and the pointer register file and is the only agent driving the file's write port.

## Interface
- LBID_W, 12, label id width
- OFS_W, 16, offset width
- PA_W, 6, pointer register address width
- LT_AW, 6, label table address width; the table is indexed by lbid[LT_AW-1:0]

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation offered
- op_ready  out  1  unit idle, can accept
- op_code  in  2  00 PLIMM, 01 PADD, 10 PCP, 11 illegal
- op_p0  in  PA_W  source pointer register
- op_pw  in  PA_W  destination pointer register
- op_imm  in  OFS_W  signed offset delta (PADD)
- op_lbid  in  LBID_W  label id (PLIMM)
- p0  out  PA_W  register-file read address
- lbid0  in  LBID_W  register-file read data, label
- ofs0  in  OFS_W  register-file read data, offset (combinational read)
- pw  out  PA_W  register-file write address
- lbidw  out  LBID_W  write data, label
- ofsw  out  OFS_W  write data, offset
- we  out  1  write enable, one-cycle pulse
- lt_we  in  1  label table write
- lt_addr  in  LT_AW  label table index
- lt_limit  in  OFS_W  label size; valid offsets are 0..limit-1
- done  out  1  one-cycle pulse, write committed
- fault  out  1  one-cycle pulse, operation dropped
- fault_code  out  2  01 underflow, 10 out of range, 11 illegal op; held until the next fault

## Operation
- FSM states: IDLE, READ, CALC, WRITE, FAULT.
- IDLE: op_ready=1. On op_valid, latch all op_* fields and go to READ.
- READ: drive p0=latched op_p0. Register lbid0/ofs0. Go to CALC.
- CALC: compute the candidate pointer.
  - PLIMM: candidate = (op_lbid, 0).
  - PADD: candidate = (lbid0, ofs0 + sext(op_imm)), computed as a 17-bit signed sum.
  - PCP: candidate = (lbid0, ofs0).
  - Illegal op_code: go to FAULT with code 11.
  - Otherwise look up limit = table[candidate lbid[LT_AW-1:0]]:
    - sum < 0: FAULT, code 01.
    - candidate ofs ≥ limit: FAULT, code 10.
    - else: WRITE.
- WRITE: we=1, pw=op_pw, lbidw/ofsw=candidate, done=1. Go to IDLE.
- FAULT: fault=1, fault_code updated, we=0. Go to IDLE.
- Label table:
  - 2^LT_AW entries of OFS_W bits, written on lt_we at the clock edge.
  - A same-cycle write and CALC lookup of the same entry uses the old value.
  - Reset clears all entries to 0, so every check faults with code 10 until the table is programmed.
- pw==op_p0 is legal; the source is sampled in READ, before the write.

## Timing
- Accept at edge N (op_valid && op_ready). READ at N+1, CALC at N+2, WRITE or FAULT at N+3. op_ready high again at N+4.
- Throughput: one operation per 4 cycles.
- A following operation reading the register just written sees the new value, because its READ is at least 2 cycles after the WRITE edge.
- Reset values: op_ready=1, we=0, done=0, fault=0, fault_code=00, p0=0, pw=0, lbidw=0, ofsw=0, state IDLE.
- Reset asserted mid-operation aborts the operation; we is 0 from the cycle after reset is sampled.
- op_valid while op_ready=0 is ignored; the producer must hold it.

## Configuration
- PTR_BOUNDS_CHECK_EN defined:
  - Label table and checks present as described.
- PTR_BOUNDS_CHECK_EN undefined:
  - No label table; lt_* ports are ignored.
  - PADD offset wraps modulo 2^OFS_W.
  - Only illegal op faults (code 11).
  - Latency is unchanged.

## Test plan
- Reset, then program table[5]=100. PLIMM lbid=5 pw=3 -> we at N+3 with pw=3, lbidw=5, ofsw=0; done pulses; op_ready high at N+4.
- Pointer r3=(5,10), PADD imm=+89 pw=4 -> ofsw=99, done. Then PADD imm=+90 -> fault, code 10, we never asserted.
- Pointer r3=(5,10), PADD imm=-11 -> fault, code 01. Same operation with PTR_BOUNDS_CHECK_EN undefined -> ofsw=0xFFFF, done.
- op_code=11 -> fault, code 11 at N+3. PCP p0=3 pw=3 -> register unchanged, done.
- Back-to-back: PADD r3+=1 into r3, three times with op_valid held -> ofs 11, 12, 13, writes at 4-cycle spacing.
- Assert reset during CALC -> no we pulse, op_ready=1 after reset. lt_we to table[5] in the same cycle as CALC -> check uses the old limit.
